// File: rtl/roe_pkg.sv
// Shared types and constants for the R.O.E register file.
package roe_pkg;

   localparam int ROE_DW   = 8;
   localparam int ROE_AW   = 4;
   localparam int ROE_NREG = 2 ** ROE_AW;

   typedef logic [ROE_AW-1:0] rf_addr_t;
   typedef logic [ROE_DW-1:0] rf_data_t;

   typedef enum logic [1:0] {
      RF_IDLE,
      RF_CLEAR,
      RF_DONE
   } rf_clr_state_t;

endpackage

// File: rtl/roe_rf_clear_fsm.sv
// Clear sequencer: sweeps every register index once, then pulses clr_done.
module roe_rf_clear_fsm
   import roe_pkg::*;
#(
   parameter int AW = ROE_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_done,
   output logic          clr_we,
   output logic [AW-1:0] clr_idx
);

   rf_clr_state_t state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RF_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr_we  = 1'b0;
      case (state_q)
         RF_IDLE: begin
            if (clr_req) begin
               state_d = RF_CLEAR;
               idx_d   = '0;
            end
         end
         RF_CLEAR: begin
            clr_we = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (idx_q == {AW{1'b1}}) state_d = RF_DONE;
         end
         RF_DONE: state_d = RF_IDLE;
         default: state_d = RF_IDLE;
      endcase
   end

   assign busy     = (state_q != RF_IDLE);
   assign clr_done = (state_q == RF_DONE);
   assign clr_idx  = idx_q;

endmodule

// File: rtl/roe_regfile.sv
// 16 x 8 register file with registered read, pipelined write and hardware clear.
// Define ROE_RF_BYPASS_EN to forward in-flight writes to the read port.
module roe_regfile
   import roe_pkg::*;
#(
   parameter int DW = ROE_DW,
   parameter int AW = ROE_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] rd_addr,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_done
);

   localparam int NREG = 2 ** AW;

   logic [DW-1:0] mem [NREG];
   logic          wb_vld;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          clr_we;
   logic [AW-1:0] clr_idx;
   logic          wr_accept;
   logic [DW-1:0] rd_sel;

   roe_rf_clear_fsm #(.AW(AW)) u_clear_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   // Outside busy the FSM is idle, so a concurrent clr_req is being accepted and wins.
   assign wr_accept = wr_en && !busy && !clr_req;

`ifdef ROE_RF_BYPASS_EN
   always_comb begin
      rd_sel = mem[rd_addr];
      if (wr_accept && (wr_addr == rd_addr))
         rd_sel = wr_data;
      else if (wb_vld && (wb_addr == rd_addr))
         rd_sel = wb_data;
   end
`else
   assign rd_sel = mem[rd_addr];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_vld  <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         wb_vld <= wr_accept;
         if (wr_accept) begin
            wb_addr <= wr_addr;
            wb_data <= wr_data;
         end
      end
   end

   // NOTE: the array is built from flops with async reset because reset must zero every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else begin
         if (wb_vld) mem[wb_addr] <= wb_data;
         if (clr_we) mem[clr_idx] <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else if (busy)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= rd_sel;
   end

endmodule

// File: tb/tb_roe_regfile.sv
// Randomized scoreboard bench for roe_regfile against an edge-timed reference model.
module tb_roe_regfile;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rd_addr = '0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       clr_req = 1'b0;
   logic       busy;
   logic       clr_done;

   roe_regfile dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_done (clr_done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: time-stamped pending writes and a clear window measured in edges.
   typedef struct {int due; logic [3:0] a; logic [7:0] d;} pend_t;
   typedef struct {logic [7:0] rd; logic busy; logic done;} exp_t;

   pend_t      pend[$];
   exp_t       sb[$];
   logic [7:0] mref [16];
   logic [7:0] rd_ref;
   int         edge_k = 0;
   int         clr_e = 0;
   bit         clr_act = 1'b0;

   function automatic void model_reset();
      foreach (mref[i]) mref[i] = 8'h00;
      pend.delete();
      rd_ref  = 8'h00;
      clr_act = 1'b0;
   endfunction

   function automatic void model_edge(input bit re, input logic [3:0] ra, input bit we,
                                      input logic [3:0] wa, input logic [7:0] wd, input bit cr);
      int   k;
      bit   idle;
      bit   wacc;
      logic [7:0] rv;
      exp_t e;
      edge_k++;
      k    = edge_k;
      idle = !(clr_act && k >= clr_e + 1 && k <= clr_e + 17);
      wacc = idle && we && !cr;
      rv   = mref[ra];
`ifdef ROE_RF_BYPASS_EN
      foreach (pend[i]) if (pend[i].due == k && pend[i].a == ra) rv = pend[i].d;
      if (wacc && wa == ra) rv = wd;
`endif
      if (!idle) rd_ref = 8'h00;
      else if (re) rd_ref = rv;
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].due == k) mref[pend[i].a] = pend[i].d;
         if (pend[i].due <= k) pend.delete(i);
      end
      if (clr_act && k >= clr_e + 1 && k <= clr_e + 16) mref[k - clr_e - 1] = 8'h00;
      if (idle && cr) begin
         clr_act = 1'b1;
         clr_e   = k;
      end
      if (wacc) pend.push_back('{k + 1, wa, wd});
      e.rd   = rd_ref;
      e.busy = clr_act && k >= clr_e && k <= clr_e + 16;
      e.done = clr_act && k == clr_e + 16;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("rd_data", 32'(rd_data), 32'(e.rd));
         check("busy", 32'(busy), 32'(e.busy));
         check("clr_done", 32'(clr_done), 32'(e.done));
      end
   end

   // Called at negedge+1; returns at the next negedge+1.
   task automatic step(input bit re, input logic [3:0] ra, input bit we,
                       input logic [3:0] wa, input logic [7:0] wd, input bit cr);
      rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; clr_req = cr;
      @(posedge clk);
      model_edge(re, ra, we, wa, wd, cr);
      @(negedge clk);
      #1;
   endtask

   task automatic idle_n(input int n);
      repeat (n) step(1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0);
   endtask

   task automatic read_all();
      for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 4'h0, 8'h00, 1'b0);
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 1'b1, 4'(i), v, 1'b0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_rd_data", 32'(rd_data), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_clr_done", 32'(clr_done), 32'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      #1;
      apply_reset();

      read_all();

      step(1'b0, 4'h0, 1'b1, 4'h3, 8'hA5, 1'b0);
      idle_n(2);
      step(1'b1, 4'h3, 1'b0, 4'h0, 8'h00, 1'b0);
      idle_n(1);

      step(1'b0, 4'h0, 1'b1, 4'h7, 8'h3C, 1'b0);
      step(1'b1, 4'h7, 1'b0, 4'h0, 8'h00, 1'b0);
      idle_n(1);
      step(1'b1, 4'h7, 1'b0, 4'h0, 8'h00, 1'b0);

      fill(8'hFF);
      idle_n(2);
      step(1'b1, 4'h2, 1'b0, 4'h0, 8'h00, 1'b1);
      for (int i = 0; i < 18; i++)
         step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)), 8'hFF, 1'b0);
      read_all();

      fill(8'hFF);
      idle_n(2);
      step(1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b1);
      idle_n(8);
      apply_reset();
      read_all();

      fill(8'h5A);
      idle_n(1);
      step(1'b0, 4'h0, 1'b1, 4'h5, 8'h11, 1'b1);
      idle_n(18);
      step(1'b1, 4'h5, 1'b0, 4'h0, 8'h00, 1'b0);
      idle_n(1);

      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), ($urandom_range(0, 39) == 0));
      idle_n(20);
      read_all();
      idle_n(2);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
